inert_spi_seq: RTL and testbench
================================

// Module: inert_spi_seq
// PURPOSE
//  Command sequencer directly upstream of the SPI master; consumes its done/rd_data.
//  After reset: waits a power-up delay, then issues three fixed init writes to the inertial sensor.
//  Then, on each data-ready interrupt (INT), reads yaw-rate low/high registers and presents a 16-bit yaw_rt with a vld pulse.
// PARAMETERS
//  TMR_W    16        width of power-up delay timer; first wrt when timer reaches all-ones
//  INIT0    16'h0D02  init write 0: enable INT on data ready
//  INIT1    16'h1160  init write 1: accel config
//  INIT2    16'h1450  init write 2: gyro config
//  RD_L     16'hA600  read command, yaw-rate low byte
//  RD_H     16'hA700  read command, yaw-rate high byte
// PORTS
//  clk      in   1   system clock
//  rst_n    in   1   reset, asynchronous, active-low
//  INT      in   1   sensor data-ready, asynchronous to clk, active-high level
//  done     in   1   SPI master transaction complete, 1-cycle pulse
//  rd_data  in   16  SPI master read data; valid in the cycle done=1
//  wrt      out  1   start SPI transaction, 1-cycle pulse
//  cmd      out  16  SPI command word; held stable from wrt until done
//  yaw_rt   out  16  latest yaw rate, signed, {high byte, low byte}
//  vld      out  1   yaw_rt updated, 1-cycle pulse
// BEHAVIOUR
//  Reset values: wrt=0, cmd=16'h0000, yaw_rt=16'h0000, vld=0, timer=0, state=PWR_WAIT.
//  INT path: 2-flop synchroniser, reset to 0; FSM uses INT_ff2 only (2-cycle latency).
//  States: PWR_WAIT, W_INIT0, W_INIT1, W_INIT2, IDLE, W_RDL, W_RDH, VALID.
//  PWR_WAIT: timer increments every clk.
//   - At timer == {TMR_W{1'b1}}: wrt=1, cmd<=INIT0, go W_INIT0.
//  W_INITn: wait for done.
//   - On done: issue the next init (wrt + cmd) in the SAME cycle; W_INIT2 done -> IDLE, no wrt.
//  IDLE: INT_ff2=1 -> wrt=1, cmd<=RD_L, go W_RDL.
//   - INT is level-sensitive: still high on return to IDLE -> another read.
//  W_RDL: on done, capture rd_data[7:0] into yaw_l; wrt=1, cmd<=RD_H; go W_RDH.
//  W_RDH: on done, capture rd_data[7:0] into yaw_h; go VALID.
//  VALID: yaw_rt<={yaw_h,yaw_l} and vld=1 for exactly this one cycle; go IDLE.
//   - Latency: done(RD_H) at cycle N -> yaw_rt/vld at cycle N+1.
//  wrt is registered: asserted in the cycle after the FSM decision; never 2 consecutive cycles.
//  cmd changes only together with a wrt pulse; otherwise holds its last value.
//  done outside W_* states: ignored. INT during init or reads: ignored (not queued).
//  yaw_rt holds between vld pulses; vld never asserted before all three inits complete.
//  No timeout on done: the sequencer waits indefinitely in a W_* state.
//  rst_n asserted mid-transaction: immediate return to reset values and PWR_WAIT; full init sequence repeats.
// TESTING
//  T1 reset, bench overrides TMR_W=4:
//   - first wrt at cycle 15 with cmd=0x0D02;
//   - model done 40 cycles after each wrt;
//   - expect cmd 0x1160 then 0x1450, then IDLE.
//  T2 INT pulse after init, rd_data low=0x34 then high=0x12:
//   - wrt cmd=0xA600, then 0xA700;
//   - yaw_rt=0x1234 with vld=1 for one cycle, one clk after second done.
//  T3 INT high throughout init: no read wrt until W_INIT2 done; then a read starts within 1 cycle of IDLE.
//  T4 INT held high continuously: back-to-back reads, yaw_rt=0xFF80 (negative) reported; vld exactly once per pair.
//  T5 stray done pulses in IDLE and PWR_WAIT: no state change, no wrt, no vld.
//  T6 rst_n low while in W_RDH: all outputs 0 asynchronously; after release, timer restarts and INIT0 is reissued.

Source files
------------

// File: rtl/inert_spi_seq.sv
// ---------------------------------------------------------------------------
// inert_spi_seq
//   Command sequencer sitting directly upstream of the SPI master. After reset
//   it waits a power-up delay, issues three fixed configuration writes to the
//   inertial sensor, then services each data-ready interrupt by reading the
//   yaw-rate low and high registers and presenting the assembled 16-bit value
//   with a one-cycle valid pulse.
//
// Ports
//   clk      in   1   system clock
//   rst_n    in   1   asynchronous active-low reset
//   INT      in   1   sensor data-ready, asynchronous level, active-high
//   done     in   1   SPI master transaction complete, 1-cycle pulse
//   rd_data  in   16  SPI master read data, valid while done=1
//   wrt      out  1   start SPI transaction, 1-cycle pulse
//   cmd      out  16  SPI command word, stable from wrt until done
//   yaw_rt   out  16  latest signed yaw rate {high byte, low byte}
//   vld      out  1   yaw_rt updated, 1-cycle pulse
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module inert_spi_seq #(
  parameter int          TMR_W = 16,
  parameter logic [15:0] INIT0 = 16'h0D02,
  parameter logic [15:0] INIT1 = 16'h1160,
  parameter logic [15:0] INIT2 = 16'h1450,
  parameter logic [15:0] RD_L  = 16'hA600,
  parameter logic [15:0] RD_H  = 16'hA700
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] yaw_rt,
  output logic        vld
);

  typedef enum logic [2:0] {
    PWR_WAIT,
    W_INIT0,
    W_INIT1,
    W_INIT2,
    IDLE,
    W_RDL,
    W_RDH,
    VALID
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [TMR_W-1:0]   r_timer;
  logic               r_int_ff1;
  logic               r_int_ff2;
  logic               r_wrt;
  logic [15:0]        r_cmd;
  logic [7:0]         r_yaw_l;
  logic [15:0]        r_yaw_rt;
  logic               r_vld;

  logic               w_timer_full;
  logic               w_wrt_set;
  logic [15:0]        w_cmd_nxt;
  logic               w_cap_l;
  logic               w_load_yaw;
  logic               w_unused_rd_hi;

  assign w_timer_full = &r_timer;

  // Only the low byte of each read carries register data.
  assign w_unused_rd_hi = ^rd_data[15:8];

  // INT is asynchronous to clk; the FSM only ever looks at the second flop.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values and the ff1 -> ff2 shift cannot collapse into one stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_int_ff1 <= 1'b0;
      r_int_ff2 <= 1'b0;
    end else begin
      r_int_ff1 <= INT;
      r_int_ff2 <= r_int_ff1;
    end
  end

  // State register and power-up timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= PWR_WAIT;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == PWR_WAIT)
        r_timer <= r_timer + TMR_W'(1);
    end
  end

  // Next-state logic. done and INT are simply not looked at in states that
  // do not expect them, which is what makes stray pulses harmless.
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      PWR_WAIT: if (w_timer_full) w_state_nxt = W_INIT0;
      W_INIT0:  if (done)         w_state_nxt = W_INIT1;
      W_INIT1:  if (done)         w_state_nxt = W_INIT2;
      W_INIT2:  if (done)         w_state_nxt = IDLE;
      IDLE:     if (r_int_ff2)    w_state_nxt = W_RDL;
      W_RDL:    if (done)         w_state_nxt = W_RDH;
      W_RDH:    if (done)         w_state_nxt = VALID;
      VALID:                      w_state_nxt = IDLE;
      default:                    w_state_nxt = PWR_WAIT;
    endcase
  end

  // Output decisions, registered below so wrt/cmd appear one cycle later.
  always_comb begin
    w_wrt_set  = 1'b0;
    w_cmd_nxt  = r_cmd;
    w_cap_l    = 1'b0;
    w_load_yaw = 1'b0;
    unique case (r_state)
      PWR_WAIT: if (w_timer_full) begin w_wrt_set = 1'b1; w_cmd_nxt = INIT0; end
      W_INIT0:  if (done)         begin w_wrt_set = 1'b1; w_cmd_nxt = INIT1; end
      W_INIT1:  if (done)         begin w_wrt_set = 1'b1; w_cmd_nxt = INIT2; end
      IDLE:     if (r_int_ff2)    begin w_wrt_set = 1'b1; w_cmd_nxt = RD_L;  end
      W_RDL:    if (done) begin
        w_wrt_set = 1'b1;
        w_cmd_nxt = RD_H;
        w_cap_l   = 1'b1;
      end
      W_RDH:    if (done)         w_load_yaw = 1'b1;
      default: ;
    endcase
  end

  // The high byte goes straight from rd_data into yaw_rt on the final done,
  // so the new value and vld both become visible in the VALID cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrt    <= 1'b0;
      r_cmd    <= 16'h0000;
      r_yaw_l  <= 8'h00;
      r_yaw_rt <= 16'h0000;
      r_vld    <= 1'b0;
    end else begin
      r_wrt <= w_wrt_set;
      r_vld <= w_load_yaw;
      r_cmd <= w_cmd_nxt;
      if (w_cap_l)
        r_yaw_l <= rd_data[7:0];
      if (w_load_yaw)
        r_yaw_rt <= {rd_data[7:0], r_yaw_l};
    end
  end

  assign wrt    = r_wrt;
  assign cmd    = r_cmd;
  assign yaw_rt = r_yaw_rt;
  assign vld    = r_vld;

endmodule

// File: tb/tb_inert_spi_seq.sv
// ---------------------------------------------------------------------------
// tb_inert_spi_seq
//   Directed bench for inert_spi_seq with a shortened power-up timer. A
//   scoreboard queue holds the command expected on each wrt and the yaw value
//   expected on each vld; entries are pushed when the stimulus that causes
//   them is driven and popped when the DUT responds. The SPI master is
//   modelled inline: done is returned 40 cycles after each wrt.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_inert_spi_seq;

  localparam int TMR_W = 4;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        INT     = 1'b0;
  logic        done    = 1'b0;
  logic [15:0] rd_data = 16'h0000;
  logic        wrt;
  logic [15:0] cmd;
  logic [15:0] yaw_rt;
  logic        vld;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_wrt    = 0;
  int          n_vld    = 0;
  int          n_b2b    = 0;
  logic        prev_wrt = 1'b0;

  logic [15:0] exp_cmd_q[$];
  logic [15:0] exp_yaw_q[$];
  logic [15:0] cur_cmd;

  inert_spi_seq #(.TMR_W(TMR_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .INT     (INT),
    .done    (done),
    .rd_data (rd_data),
    .wrt     (wrt),
    .cmd     (cmd),
    .yaw_rt  (yaw_rt),
    .vld     (vld)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled on the falling edge.
  always @(negedge clk) begin
    prev_wrt <= wrt;
    if (wrt)             n_wrt <= n_wrt + 1;
    if (wrt && prev_wrt) n_b2b <= n_b2b + 1;
    if (vld)             n_vld <= n_vld + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for wrt, check how many falling edges it took and the
  // command it carries against the head of the scoreboard.
  task automatic wait_wrt(input string tag, input int exp_cyc);
    int cyc = 0;
    while (!wrt && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, exp_cyc);
    cur_cmd = exp_cmd_q.pop_front();
    check({tag, "_cmd"}, cmd, cur_cmd);
  endtask

  // SPI master model: done 40 cycles after wrt, with read data alongside.
  task automatic spi_done(input string tag, input logic [15:0] data);
    repeat (40) @(negedge clk);
    check({tag, "_cmd_held"}, cmd, cur_cmd);
    done    = 1'b1;
    rd_data = data;
    @(negedge clk);
    done    = 1'b0;
    rd_data = 16'hDEAD;
  endtask

  task automatic check_result(input string tag);
    logic [15:0] e;
    e = exp_yaw_q.pop_front();
    check({tag, "_vld"}, vld, 1);
    check({tag, "_yaw"}, yaw_rt, e);
    @(negedge clk);
    check({tag, "_vld_one_cycle"}, vld, 0);
    check({tag, "_yaw_hold"}, yaw_rt, e);
  endtask

  // Completes a read pair once the RD_L wrt has been seen.
  task automatic read_pair(input string tag, input logic [15:0] lo, input logic [15:0] hi,
                           input logic [15:0] exp_yaw);
    exp_cmd_q.push_back(16'hA700);
    spi_done({tag, "_rdl"}, lo);
    wait_wrt({tag, "_rdh"}, 0);
    exp_yaw_q.push_back(exp_yaw);
    spi_done({tag, "_rdh"}, hi);
    check_result(tag);
  endtask

  // Caller pushes INIT0 when releasing reset.
  task automatic run_init(input string tag, input int lat0);
    wait_wrt({tag, "_init0"}, lat0);
    exp_cmd_q.push_back(16'h1160);
    spi_done({tag, "_init0"}, 16'h0000);
    wait_wrt({tag, "_init1"}, 0);
    exp_cmd_q.push_back(16'h1450);
    spi_done({tag, "_init1"}, 16'h0000);
    wait_wrt({tag, "_init2"}, 0);
    spi_done({tag, "_init2"}, 16'h0000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int v0;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_wrt", wrt, 0);
    check("rst_cmd", cmd, 16'h0000);
    check("rst_yaw", yaw_rt, 16'h0000);
    check("rst_vld", vld, 0);

    // T1: timer counts 0..15 (15 edges), wrt registered one edge later:
    // 16 falling edges after release, i.e. cycle 15 counting from 0.
    exp_cmd_q.push_back(16'h0D02);
    rst_n = 1'b1;
    run_init("t1", 16);

    // T5: stray done pulses in IDLE.
    w0 = n_wrt;
    v0 = n_vld;
    repeat (5) @(negedge clk);
    done = 1'b1; rd_data = 16'h00AA;
    @(negedge clk);
    done = 1'b0;
    repeat (3) @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    repeat (10) @(negedge clk);
    check("t5_idle_no_wrt", n_wrt - w0, 0);
    check("t5_idle_no_vld", n_vld - v0, 0);

    // T2: short INT pulse; 2 synchroniser flops + 1 registered wrt.
    INT = 1'b1;
    exp_cmd_q.push_back(16'hA600);
    wait_wrt("t2_rdl", 3);
    INT = 1'b0;
    read_pair("t2", 16'hAB34, 16'hCD12, 16'h1234);
    w0 = n_wrt;
    repeat (20) @(negedge clk);
    check("t2_single_read", n_wrt - w0, 0);

    // T4: INT held high, back-to-back reads.
    INT = 1'b1;
    exp_cmd_q.push_back(16'hA600);
    wait_wrt("t4_p1_rdl", 3);
    v0 = n_vld;
    read_pair("t4_p1", 16'h0080, 16'h00FF, 16'hFF80);
    exp_cmd_q.push_back(16'hA600);
    wait_wrt("t4_p2_rdl", 1);
    read_pair("t4_p2", 16'h3301, 16'h4400, 16'h0001);
    exp_cmd_q.push_back(16'hA600);
    wait_wrt("t4_p3_rdl", 1);
    check("t4_vld_per_pair", n_vld - v0, 2);

    // T6: reset while waiting in W_RDH.
    exp_cmd_q.push_back(16'hA700);
    spi_done("t6_rdl", 16'h0011);
    wait_wrt("t6_rdh", 0);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_wrt", wrt, 0);
    check("t6_async_cmd", cmd, 16'h0000);
    check("t6_async_yaw", yaw_rt, 16'h0000);
    check("t6_async_vld", vld, 0);
    repeat (2) @(negedge clk);

    // Restart with INT still high (T3) and a stray done in PWR_WAIT (T5).
    w0 = n_wrt;
    exp_cmd_q.push_back(16'h0D02);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    run_init("t6", 11);
    check("t6_init_wrt_count", n_wrt - w0, 3);

    // T3: read starts one cycle after entering IDLE.
    exp_cmd_q.push_back(16'hA600);
    wait_wrt("t3_rdl", 1);
    INT = 1'b0;
    read_pair("t3", 16'h0078, 16'h0056, 16'h5678);

    repeat (5) @(negedge clk);
    check("wrt_never_back_to_back", n_b2b, 0);
    check("sb_cmd_empty", exp_cmd_q.size(), 0);
    check("sb_yaw_empty", exp_yaw_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
